conv_pool_ctrl: RTL and testbench
=================================

CONV_POOL_CTRL -- requirements
Module: conv_pool_ctrl

Interface
REQ-001 Parameter IMG_W, default 28: input image width and height, in pixels.
REQ-002 Parameter K, default 5: kernel side; window holds K*K = 25 pixels.
REQ-003 Parameter IntSize, default 8: pixel and pooled-output width.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to process one image.
REQ-007 busy  output  1  high from the cycle after start is accepted until done.
REQ-008 done  output  1  one-cycle pulse after the last pooled output's handshake.
REQ-009 pix_rd  output  1  pixel read strobe.
REQ-010 pix_addr  output  10  row-major pixel address (row*IMG_W+col).
REQ-011 pix_data  input  IntSize  read data, valid exactly one cycle after pix_rd.
REQ-012 win  output  K*K*IntSize  window bus to the dot-product unit; slot k=i*K+j occupies bits [IntSize*k+IntSize-1 : IntSize*k].
REQ-013 dp_result  input  IntSize+1  combinational dot-product result of win.
REQ-014 pool_valid  output  1  pooled result available.
REQ-015 pool_ready  input  1  consumer accepts pool_data when high together with pool_valid.
REQ-016 pool_data  output  IntSize  2x2 max of saturated conv results.

Function
REQ-017 States SHALL be IDLE, FETCH, WAIT, EVAL, OUT, DONE.
REQ-018 IDLE: start=1 -> FETCH, with conv row/col counters cleared; start in any other state SHALL be ignored.
REQ-019 FETCH: 25 consecutive cycles, pix_rd=1, pix_addr=(r+i)*IMG_W+(c+j), k ascending 0..24 (i=k/K, j=k%K); then -> WAIT.
REQ-020 pix_data returned for read k SHALL be written into win slot k on the following edge; win holds its value otherwise.
REQ-021 WAIT: one cycle, pix_rd=0 (slot 24 lands); -> EVAL.
REQ-022 EVAL: one cycle; sat(dp_result) captured into quad register q[n], where sat(x) = 2^IntSize-1 if x >= 2^IntSize, else x[IntSize-1:0].
REQ-023 Conv positions SHALL be visited per pooled cell (pr,pc) in order n=0:(2pr,2pc), 1:(2pr,2pc+1), 2:(2pr+1,2pc), 3:(2pr+1,2pc+1); EVAL with n<3 -> FETCH for the next position; n=3 -> OUT.
REQ-024 Conv latency: 27 cycles per conv position; the first pool_valid SHALL assert 108 cycles after the FETCH entry for n=0.
REQ-025 OUT: pool_valid=1, pool_data=max(q0,q1,q2,q3) unsigned, both held stable until pool_ready=1.
REQ-026 Pooled cells SHALL be traversed row-major over (IMG_W-K+1)/2 = 12 x 12 = 144 cells.
REQ-027 OUT with handshake and cell not last -> FETCH for the next cell; last cell -> DONE.
REQ-028 DONE: one cycle, done=1, busy=0 -> IDLE.
REQ-029 busy SHALL be 1 in FETCH, WAIT, EVAL and OUT, and 0 in IDLE and DONE.
REQ-030 pix_rd SHALL never assert outside FETCH, and pool_valid SHALL never assert outside OUT.

Reset
REQ-031 rst=1 SHALL immediately force IDLE; busy, done, pix_rd and pool_valid = 0; pix_addr, pool_data, win, q[0..3] and all counters = 0.
REQ-032 Reset mid-operation SHALL abandon the image with no further pix_rd or pool_valid; a new start after deassertion SHALL begin at cell (0,0).

Verification
REQ-033 Address check: start -> first 25 pix_addr = 0,1,2,3,4,28..32,56..60,84..88,112..116; the next conv (n=1) starts at addr 1.
REQ-034 All-ones image, bench model dp_result = sum of win lanes (weights 1) -> 144 outputs, each pool_data=25; done after the 144th handshake.
REQ-035 Saturation/max: bench forces dp_result = 300,10,20,30 for n=0..3 -> pool_data=255; forced 5,90,7,89 -> pool_data=90.
REQ-036 Backpressure: pool_ready held 0 for 10 cycles in OUT -> pool_valid and pool_data stable, no pix_rd; then ready=1 -> FETCH the next cycle.
REQ-037 start pulsed while busy -> ignored, output count still 144; rst asserted during the 50th FETCH -> all outputs 0 at once, IDLE, then a fresh start issues pix_addr 0.

Source files
------------

// File: rtl/conv_pool_ctrl.sv
// rtl/conv_pool_ctrl.sv - conv window sequencer with saturating 2x2 max-pool output stage
//
// Purpose: walks a KxK window over an IMG_W x IMG_W image. For each pooled cell it
// fetches the four conv positions of the 2x2 quad, captures the saturated dot-product
// result of each, then offers max(q0..q3) on a valid/ready output.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle request to process one image (honoured only in IDLE)
//   busy, done      busy in FETCH/WAIT/EVAL/OUT; done pulses for one cycle at the end
//   pix_rd/pix_addr pixel read strobe and row-major address
//   pix_data        read data, returned one cycle after pix_rd
//   win             K*K pixel lanes to the dot-product unit (lane k = bits [8k+7:8k])
//   dp_result       combinational dot-product of win (IntSize+1 bits)
//   pool_valid/pool_ready/pool_data  pooled output handshake
module conv_pool_ctrl #(
  parameter int IMG_W   = 28,
  parameter int K       = 5,
  parameter int IntSize = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   pix_rd,
  output logic [9:0]             pix_addr,
  input  logic [IntSize-1:0]     pix_data,
  output logic [K*K*IntSize-1:0] win,
  input  logic [IntSize:0]       dp_result,
  output logic                   pool_valid,
  input  logic                   pool_ready,
  output logic [IntSize-1:0]     pool_data
);

  localparam int NP = (IMG_W - K + 1) / 2;
  localparam int KK = K * K;
  localparam int KW = $clog2(KK);
  localparam int IW = $clog2(K);
  localparam int PW = $clog2(NP);

  localparam logic [KW-1:0] K_LAST = KW'(KK - 1);
  localparam logic [IW-1:0] J_LAST = IW'(K - 1);
  localparam logic [PW-1:0] P_LAST = PW'(NP - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    EVAL  = 3'd3,
    OUT   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0]      pr, pc;      // pooled cell
  logic [1:0]         n;           // position inside the 2x2 quad
  logic [KW-1:0]      k;           // window slot being read
  logic [IW-1:0]      i, j;        // k split into window row/col
  logic [KW-1:0]      k_d;         // slot of the read whose data arrives now
  logic               rd_d;
  logic [IntSize-1:0] q [4];
  logic [IntSize-1:0] sat_res;
  logic [IntSize-1:0] m01, m23;
  logic [9:0]         row, col;
  logic               last_cell;

  // Conv position (r,c) = (2pr + n[1], 2pc + n[0]); add the window offset (i,j).
  assign row = 10'({pr, 1'b0}) + 10'(n[1]) + 10'(i);
  assign col = 10'({pc, 1'b0}) + 10'(n[0]) + 10'(j);
  assign pix_addr = (state == FETCH) ? (row * 10'(IMG_W) + col) : '0;

  // The MSB of dp_result set means the value is >= 2^IntSize.
  assign sat_res = dp_result[IntSize] ? '1 : dp_result[IntSize-1:0];

  assign m01       = (q[0] > q[1]) ? q[0] : q[1];
  assign m23       = (q[2] > q[3]) ? q[2] : q[3];
  assign pool_data = (m01 > m23) ? m01 : m23;

  assign last_cell = (pr == P_LAST) && (pc == P_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    done       = 1'b0;
    pix_rd     = 1'b0;
    pool_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        busy   = 1'b1;
        pix_rd = 1'b1;
        if (k == K_LAST) state_nxt = WAIT;
      end
      WAIT: begin
        busy      = 1'b1;
        state_nxt = EVAL;
      end
      EVAL: begin
        busy      = 1'b1;
        state_nxt = (n == 2'd3) ? OUT : FETCH;
      end
      OUT: begin
        busy       = 1'b1;
        pool_valid = 1'b1;
        if (pool_ready) state_nxt = last_cell ? DONE : FETCH;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pr   <= '0;
      pc   <= '0;
      n    <= '0;
      k    <= '0;
      i    <= '0;
      j    <= '0;
      k_d  <= '0;
      rd_d <= 1'b0;
      win  <= '0;
      for (int s = 0; s < 4; s++) q[s] <= '0;
    end else begin
      rd_d <= pix_rd;
      k_d  <= k;
      // Read data lags its strobe by one cycle, so lane k_d is filled here.
      for (int s = 0; s < KK; s++) begin
        if (rd_d && (k_d == KW'(s))) win[s*IntSize +: IntSize] <= pix_data;
      end
      case (state)
        IDLE: begin
          if (start) begin
            pr <= '0;
            pc <= '0;
            n  <= '0;
            k  <= '0;
            i  <= '0;
            j  <= '0;
          end
        end
        FETCH: begin
          if (k == K_LAST) begin
            k <= '0;
            i <= '0;
            j <= '0;
          end else begin
            k <= k + 1'b1;
            if (j == J_LAST) begin
              j <= '0;
              i <= i + 1'b1;
            end else begin
              j <= j + 1'b1;
            end
          end
        end
        EVAL: begin
          q[n] <= sat_res;
          n    <= n + 1'b1;    // wraps 3 -> 0 for the next cell
        end
        OUT: begin
          if (pool_ready) begin
            if (last_cell) begin
              pr <= '0;
              pc <= '0;
            end else if (pc == P_LAST) begin
              pc <= '0;
              pr <= pr + 1'b1;
            end else begin
              pc <= pc + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_pool_ctrl.sv
// tb/tb_conv_pool_ctrl.sv - randomized self-checking bench for conv_pool_ctrl
module tb_conv_pool_ctrl;

  localparam int IMG_W = 28;
  localparam int K     = 5;
  localparam int NP    = 12;
  localparam int NCELL = NP * NP;

  logic         clk;
  logic         rst;
  logic         start;
  logic         busy;
  logic         done;
  logic         pix_rd;
  logic [9:0]   pix_addr;
  logic [7:0]   pix_data;
  logic [199:0] win;
  logic [8:0]   dp_result;
  logic         pool_valid;
  logic         pool_ready;
  logic [7:0]   pool_data;

  int total = 0;
  int bad   = 0;

  logic [7:0] img [IMG_W*IMG_W];
  int         wt  [K*K];
  int         fv  [NCELL*4];
  int         dp_mode;
  int         rd_cnt = 0;
  int         rd_base;
  int         dp_sum, dp_cnt;
  int         exp_q [$];

  conv_pool_ctrl #(.IMG_W(IMG_W), .K(K), .IntSize(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .pix_rd     (pix_rd),
    .pix_addr   (pix_addr),
    .pix_data   (pix_data),
    .win        (win),
    .dp_result  (dp_result),
    .pool_valid (pool_valid),
    .pool_ready (pool_ready),
    .pool_data  (pool_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel memory: one-cycle read latency.
  always @(posedge clk) begin
    if (pix_rd) begin
      pix_data <= img[pix_addr];
      rd_cnt   <= rd_cnt + 1;
    end
  end

  // Dot-product unit stand-in: weighted lane sum, or a forced value per conv position.
  always_comb begin
    dp_sum = 0;
    dp_cnt = rd_cnt - rd_base;
    if (dp_mode == 0) begin
      for (int s = 0; s < K*K; s++) dp_sum = dp_sum + wt[s] * int'(win[s*8 +: 8]);
    end else begin
      dp_sum = fv[((dp_cnt > 0) ? (dp_cnt - 1) / (K*K) : 0) % (NCELL*4)];
    end
    dp_result = (dp_sum > 511) ? 9'd511 : 9'(dp_sum);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic int conv_ref(input int r, input int c);
    int s;
    s = 0;
    for (int a = 0; a < K; a++)
      for (int b = 0; b < K; b++)
        s += wt[a*K+b] * int'(img[(r+a)*IMG_W + c + b]);
    if (s > 511) s = 511;
    return (s > 255) ? 255 : s;
  endfunction

  task automatic build_expected();
    int best, v;
    exp_q.delete();
    for (int p = 0; p < NCELL; p++) begin
      best = 0;
      for (int m = 0; m < 4; m++) begin
        if (dp_mode == 0) v = conv_ref(2*(p/NP) + m/2, 2*(p%NP) + m%2);
        else              v = (fv[4*p+m] > 255) ? 255 : fv[4*p+m];
        if (v > best) best = v;
      end
      exp_q.push_back(best);
    end
  endtask

  task automatic run_image(input bit bp, input bit spam, input bit abort);
    int cyc, reads, outs, hold, m, kk, p, nn, ea;
    logic [7:0] held;
    bit seen_valid, want_fetch;
    build_expected();
    rd_base = rd_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0; reads = 0; outs = 0; hold = 0; held = '0;
    seen_valid = 0; want_fetch = 0;
    while (outs < NCELL && cyc < 40000) begin
      chk("busy_run", busy, 1);
      chk("rd_valid_excl", pix_rd & pool_valid, 0);
      if (want_fetch) begin
        chk("bp_then_fetch", pix_rd, 1);
        want_fetch = 0;
      end
      if (pix_rd) begin
        m = reads / (K*K); kk = reads % (K*K); p = m / 4; nn = m % 4;
        ea = (2*(p/NP) + nn/2 + kk/K) * IMG_W + 2*(p%NP) + nn%2 + kk%K;
        chk("pix_addr", pix_addr, ea);
        reads++;
        if (abort && reads == 50) begin
          #1 rst = 1'b1;
          #1;
          chk("rst_busy", busy, 0);
          chk("rst_done", done, 0);
          chk("rst_pix_rd", pix_rd, 0);
          chk("rst_pool_valid", pool_valid, 0);
          chk("rst_pix_addr", pix_addr, 0);
          chk("rst_pool_data", pool_data, 0);
          chk("rst_win", 32'(|win), 0);
          @(negedge clk); rst = 1'b0;
          repeat (5) begin
            @(negedge clk);
            chk("post_rst_quiet", {pix_rd, pool_valid, busy}, 0);
          end
          return;
        end
      end
      if (pool_valid && !seen_valid) begin
        chk("first_valid_latency", cyc, 108);
        seen_valid = 1;
      end
      if (bp && outs == 0 && (hold > 0 || pool_valid) && hold < 10) begin
        if (hold == 0) held = pool_data;
        else begin
          chk("bp_valid_held", pool_valid, 1);
          chk("bp_data_held", pool_data, held);
          chk("bp_no_rd", pix_rd, 0);
        end
        pool_ready = 1'b0;
        hold++;
      end else if (bp && outs == 0 && hold == 10) begin
        pool_ready = 1'b1;
      end else begin
        pool_ready = ($urandom_range(3) != 0);
      end
      if (pool_valid && pool_ready) begin
        chk("pool_data", pool_data, exp_q[outs]);
        if (bp && outs == 0) want_fetch = 1;
        outs++;
      end
      start = spam && (outs < NCELL - 4) && (cyc % 997 == 500);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    pool_ready = 1'b0;
    chk("out_count", outs, NCELL);
    chk("read_count", reads, NCELL * 4 * K * K);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_no_valid", pool_valid, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pool_ready = 1'b0; dp_mode = 0; rd_base = 0;
    for (int a = 0; a < IMG_W*IMG_W; a++) img[a] = 8'd1;
    for (int s = 0; s < K*K; s++) wt[s] = 1;
    for (int s = 0; s < NCELL*4; s++) fv[s] = $urandom_range(511);
    fv[0] = 300; fv[1] = 10; fv[2] = 20; fv[3] = 30;
    fv[4] = 5;   fv[5] = 90; fv[6] = 7;  fv[7] = 89;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_pix_rd", pix_rd, 0);
    chk("reset_pool_valid", pool_valid, 0);
    chk("reset_pix_addr", pix_addr, 0);
    chk("reset_pool_data", pool_data, 0);
    chk("reset_win", 32'(|win), 0);
    rst = 1'b0;
    @(negedge clk);

    // All-ones image, unit weights: every pooled output is 25.
    run_image(1'b1, 1'b1, 1'b0);

    // Random image and weights; first pass is cut short by reset.
    for (int a = 0; a < IMG_W*IMG_W; a++) img[a] = 8'($urandom_range(31));
    for (int s = 0; s < K*K; s++) wt[s] = $urandom_range(1);
    run_image(1'b0, 1'b0, 1'b1);
    run_image(1'b0, 1'b1, 1'b0);

    // Forced dot-product values: saturation and max selection.
    dp_mode = 1;
    run_image(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
